// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer: zero-latency lookup of the fetch PC,
// written/invalidated from EX on resolved control transfers, cleared by fence.i.
module branch_target_buffer #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PL_stall,
    input  logic [31:0] pc,
    output logic        btb_hit,
    output logic [31:0] btb_target,
    output logic [1:0]  btb_type,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_type,
    input  logic        inv_en,
    input  logic        flush_all,
    output logic [31:0] lookup_cnt,
    output logic [31:0] hit_cnt
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int TOP  = INDEX_WIDTH + TAG_WIDTH + 2;

    // Set state is reset; the payload arrays are plain storage qualified by valid.
    logic [SETS-1:0][1:0]   valid_q;
    logic [SETS-1:0]        lru_q;
    logic [TAG_WIDTH-1:0]   tag_mem [SETS][2];
    logic [31:0]            tgt_mem [SETS][2];
    logic [1:0]             typ_mem [SETS][2];
    logic [31:0]            lookup_cnt_q, hit_cnt_q;

    logic [INDEX_WIDTH-1:0] idx, uidx;
    logic [TAG_WIDTH-1:0]   tag, utag;
    logic [1:0]             hit_v, umatch_v;
    logic                   hit_way, upd_way, inv_way, wr_en;

    assign idx  = pc[INDEX_WIDTH+1:2];
    assign tag  = pc[TOP-1:INDEX_WIDTH+2];
    assign uidx = upd_pc[INDEX_WIDTH+1:2];
    assign utag = upd_pc[TOP-1:INDEX_WIDTH+2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign hit_v[w]    = valid_q[idx][w] && (tag_mem[idx][w] == tag);
        assign umatch_v[w] = valid_q[uidx][w] && (tag_mem[uidx][w] == utag);
    end

    // Way 0 wins a (should-not-happen) double match on both ports.
    assign hit_way    = !hit_v[0];
    assign inv_way    = !umatch_v[0];
    assign btb_hit    = |hit_v;
    assign btb_target = btb_hit ? tgt_mem[idx][hit_way] : 32'd0;
    assign btb_type   = btb_hit ? typ_mem[idx][hit_way] : 2'b00;
    assign lookup_cnt = lookup_cnt_q;
    assign hit_cnt    = hit_cnt_q;
    assign wr_en      = upd_en && !inv_en && !flush_all;

    always_comb begin
        upd_way = lru_q[uidx];
        if (umatch_v[0])           upd_way = 1'b0;
        else if (umatch_v[1])      upd_way = 1'b1;
        else if (!valid_q[uidx][0]) upd_way = 1'b0;
        else if (!valid_q[uidx][1]) upd_way = 1'b1;
    end

    // Later assignments win: EX update/invalidate beats the lookup LRU touch, flush beats all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            lru_q        <= '0;
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            if (!PL_stall) begin
                lookup_cnt_q <= lookup_cnt_q + 32'd1;
                if (btb_hit) begin
                    hit_cnt_q  <= hit_cnt_q + 32'd1;
                    lru_q[idx] <= ~hit_way;
                end
            end
            if (flush_all) begin
                valid_q <= '0;
                lru_q   <= '0;
            end else if (inv_en) begin
                if (|umatch_v) begin
                    valid_q[uidx][inv_way] <= 1'b0;
                    lru_q[uidx]            <= inv_way;
                end
            end else if (upd_en) begin
                valid_q[uidx][upd_way] <= 1'b1;
                lru_q[uidx]            <= ~upd_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[uidx][upd_way] <= utag;
            tgt_mem[uidx][upd_way] <= upd_target;
            typ_mem[uidx][upd_way] <= upd_type;
        end
    end

    logic unused_lo;
    assign unused_lo = ^{pc[1:0], upd_pc[1:0]};
    if (TOP < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{pc[31:TOP], upd_pc[31:TOP]};
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- 2-way set-associative BTB in the IF stage, directly upstream of the branch predictor.
- Looks up the fetch PC in the same cycle and reports hit, predicted target and control-flow class.
- The fetch mux combines this output with the B-type direction prediction and the RAS jalr prediction to pick the next PC.
- Entries are written and invalidated from EX on resolved control transfers; fence.i clears the whole buffer.

Parameters:
- INDEX_WIDTH, 6, set index bits (2^INDEX_WIDTH sets); index = pc[INDEX_WIDTH+1:2].
- TAG_WIDTH, 10, tag bits; tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2]. INDEX_WIDTH+TAG_WIDTH+2 <= 32 required.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PL_stall  in  1  fetch stall; suppresses LRU touch and perf counting.
- pc  in  32  IF fetch PC.
- btb_hit  out  1  valid tag match for pc.
- btb_target  out  32  stored target; 0 when !btb_hit.
- btb_type  out  2  00 B-type, 01 jal, 10 jalr-return, 11 jalr-other; 00 when !btb_hit.
- upd_en  in  1  EX write request.
- upd_pc  in  32  PC of the resolved instruction.
- upd_target  in  32  resolved target.
- upd_type  in  2  class, encoded as btb_type.
- inv_en  in  1  EX invalidate request for upd_pc (non-branch hit alias).
- flush_all  in  1  fence.i; clears all valid bits.
- lookup_cnt  out  32  counted lookups.
- hit_cnt  out  32  counted hits.

Behaviour:
- State per set: valid[2], lru (way to victimise next); per way: tag, target, type.
- Only valid, lru and the counters are reset. Tag, target and type arrays are unreset storage.
- Reset (async, rst_n=0): all valid=0, all lru=0, lookup_cnt=hit_cnt=0. Consequently btb_hit=0, btb_target=0, btb_type=00 immediately, without waiting for a clock edge.
- Lookup is purely combinational, zero latency. Way k hits when valid[k] && tag[k]==tag(pc).
- If both ways hit (must not occur), way 0 wins.
- Registered lookup effects, at posedge with !PL_stall:
  - lookup_cnt increments.
  - On a hit, hit_cnt increments and lru of that set is set to the other way.
  - Counters wrap at 2^32.
- Update, at posedge with upd_en, independent of PL_stall. Way selection in priority order:
  - the way whose tag matches upd_pc and is valid;
  - otherwise invalid way 0, then invalid way 1;
  - otherwise the lru way.
  - Write: tag, target, type; set valid=1; set lru = other way.
- Invalidate, at posedge with inv_en: a matching valid way gets valid=0 and lru = that way. On a miss there is no change.
- inv_en and upd_en in the same cycle is illegal; inv_en wins and the update is dropped.
- Same-set collision: when an update or invalidate and a lookup LRU touch hit the same set in one cycle, the update/invalidate LRU value wins.
- flush_all at posedge clears all valid bits and all lru bits, and overrides upd_en and inv_en that cycle. Counters are unaffected.
- Write-then-read: a lookup in the cycle of the write sees the old contents. The new entry is visible from the next cycle.
- pc[1:0] and upd_pc[1:0] are ignored.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with prior entries -> btb_hit=0, btb_target=0, counters=0 immediately; pc=0x100 after release -> miss.
- Fill/hit:
  - upd_en, upd_pc=0x0000_1004, target=0x0000_0F00, type=00; next cycle pc=0x1004 -> hit=1, target=0x0F00, type=00.
  - pc=0x1008 -> miss.
- Associativity/LRU:
  - Write A=0x1004, then B=0x2004 (same index, different tag) -> both hit.
  - Look up A (not stalled), then write C=0x3004 -> C replaces B; B misses, A and C hit.
- Overwrite and stall:
  - Re-update 0x1004 with target 0x0800 -> same way reused, hit target 0x0800.
  - PL_stall=1 for 3 lookup cycles -> lookup_cnt and hit_cnt unchanged.
- Invalidate/flush:
  - inv_en for 0x1004 -> next cycle miss, other way still hits.
  - flush_all with simultaneous upd_en -> all lookups miss; that update is not written.
- Counters: 10 unstalled lookups, 4 hits -> lookup_cnt=10, hit_cnt=4.
